// File: rtl/rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rom_arbiter
// Purpose  : DEPTH x DW register table shared by two read requesters (A, B).
//            After reset an init sequencer fills entry i with (2*i) mod 2**DW
//            over DEPTH cycles (busy high), then the table serves single-cycle
//            reads with round-robin arbitration. A config port may overwrite
//            entries while running; a config write takes the table for that
//            cycle and no read is accepted.
// Ports    : clk, rst                  clock, synchronous active-high reset
//            cfg_we_i/addr_i/data_i    table write port (ignored while busy)
//            a_req_i/a_addr_i          requester A read request + address
//            b_req_i/b_addr_i          requester B read request + address
//            a_ack_o/b_ack_o           combinational accept
//            a_valid_o/b_valid_o       registered one-cycle data-valid pulse
//            a_data_o/b_data_o         registered read data (held when idle)
//            busy_o                    table initialisation in progress
// Revision : 1.0 - initial release
// ============================================================================
module rom_arbiter #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,   // DEPTH must equal 2**AW
  parameter int DW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we_i,
  input  logic [AW-1:0] cfg_addr_i,
  input  logic [DW-1:0] cfg_data_i,
  input  logic          a_req_i,
  input  logic [AW-1:0] a_addr_i,
  input  logic          b_req_i,
  input  logic [AW-1:0] b_addr_i,
  output logic          a_ack_o,
  output logic          b_ack_o,
  output logic          a_valid_o,
  output logic          b_valid_o,
  output logic [DW-1:0] a_data_o,
  output logic [DW-1:0] b_data_o,
  output logic          busy_o
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic          GNT_A    = 1'b0;
  localparam logic          GNT_B    = 1'b1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          last_grant_q, last_grant_d;
  logic          a_valid_q, b_valid_q;
  logic [DW-1:0] a_data_q, a_data_d;
  logic [DW-1:0] b_data_q, b_data_d;
  logic [DW-1:0] tbl_q [DEPTH];

  logic          tbl_we;
  logic [AW-1:0] tbl_waddr;
  logic [DW-1:0] tbl_wdata;
  logic          a_grant, b_grant;

  // --------------------------------------------------------------------------
  // Next-state, arbitration and table-write selection
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    a_grant      = 1'b0;
    b_grant      = 1'b0;
    tbl_we       = 1'b0;
    tbl_waddr    = cnt_q;
    tbl_wdata    = DW'({cnt_q, 1'b0});

    case (state_q)
      ST_INIT: begin
        // Sequencer owns the table; config writes are dropped, reads wait.
        tbl_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cfg_we_i) begin
          // A config write steals the cycle so a read never races the write.
          tbl_we    = 1'b1;
          tbl_waddr = cfg_addr_i;
          tbl_wdata = cfg_data_i;
        end else if (a_req_i && b_req_i) begin
          // Contention: grant whoever was not served last.
          if (last_grant_q == GNT_B) begin
            a_grant = 1'b1;
          end else begin
            b_grant = 1'b1;
          end
        end else begin
          a_grant = a_req_i;
          b_grant = b_req_i;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    // Nothing is accepted or written while reset is asserted.
    if (rst) begin
      a_grant = 1'b0;
      b_grant = 1'b0;
      tbl_we  = 1'b0;
    end

    if (a_grant) begin
      last_grant_d = GNT_A;
    end else if (b_grant) begin
      last_grant_d = GNT_B;
    end

    // Read data is captured only on a grant so outputs hold otherwise.
    a_data_d = a_grant ? tbl_q[a_addr_i] : a_data_q;
    b_data_d = b_grant ? tbl_q[b_addr_i] : b_data_q;
  end

  // --------------------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      last_grant_q <= GNT_B;
      a_valid_q    <= 1'b0;
      b_valid_q    <= 1'b0;
      a_data_q     <= '0;
      b_data_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      a_valid_q    <= a_grant;
      b_valid_q    <= b_grant;
      a_data_q     <= a_data_d;
      b_data_q     <= b_data_d;
    end
  end

  // Table storage needs no reset: INIT rewrites every entry afterwards.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      tbl_q[tbl_waddr] <= tbl_wdata;
    end
  end

  assign a_ack_o   = a_grant;
  assign b_ack_o   = b_grant;
  assign a_valid_o = a_valid_q;
  assign b_valid_o = b_valid_q;
  assign a_data_o  = a_data_q;
  assign b_data_o  = b_data_q;
  // Reset is folded in so busy reads high during the reset cycle itself.
  assign busy_o    = (state_q == ST_INIT) || rst;

endmodule
`default_nettype wire

// File: tb/tb_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_arbiter
// Purpose  : Directed self-checking bench for rom_arbiter (DEPTH 8, DW 4).
//            Inputs change 1 time unit after the rising edge; registered
//            outputs are checked there, combinational acks 1 unit later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_arbiter;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DW    = 4;

  logic          clk;
  logic          rst;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_data;
  logic          a_req, b_req;
  logic [AW-1:0] a_addr, b_addr;
  logic          a_ack, b_ack, a_valid, b_valid, busy;
  logic [DW-1:0] a_data, b_data;

  int tests = 0;
  int fails = 0;
  int n;

  rom_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we_i   (cfg_we),
    .cfg_addr_i (cfg_addr),
    .cfg_data_i (cfg_data),
    .a_req_i    (a_req),
    .a_addr_i   (a_addr),
    .b_req_i    (b_req),
    .b_addr_i   (b_addr),
    .a_ack_o    (a_ack),
    .b_ack_o    (b_ack),
    .a_valid_o  (a_valid),
    .b_valid_o  (b_valid),
    .a_data_o   (a_data),
    .b_data_o   (b_data),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Pulse reset for one cycle, then count busy cycles (bounded).
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    chk("init_len", n, 8);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    a_req = 1'b0; a_addr = '0; b_req = 1'b0; b_addr = '0;

    // ---- reset state ------------------------------------------------------
    tick();
    chk("rst_busy",    busy,    1);
    chk("rst_a_valid", a_valid, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_a_data",  a_data,  0);
    chk("rst_b_data",  b_data,  0);
    chk("rst_a_ack",   a_ack,   0);
    chk("rst_b_ack",   b_ack,   0);

    // ---- busy exactly 8 cycles, then single read of addr 5 ----------------
    rst = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    chk("busy_len", n, 8);
    a_req = 1'b1; a_addr = 3'd5;
    #1;
    chk("rd5_a_ack", a_ack, 1);
    chk("rd5_b_ack", b_ack, 0);
    tick();
    chk("rd5_a_valid", a_valid, 1);
    chk("rd5_a_data",  a_data,  10);
    chk("rd5_b_valid", b_valid, 0);
    a_req = 1'b0;
    #1;
    chk("rd5_ack_drop", a_ack, 0);
    tick();
    chk("rd5_valid_pulse", a_valid, 0);
    chk("rd5_data_hold",   a_data,  10);

    // ---- request from B held through INIT --------------------------------
    rst = 1'b1;
    tick();
    rst = 1'b0;
    b_req = 1'b1; b_addr = 3'd2;
    n = 0;
    while (busy && n < 20) begin
      #1;
      chk("init_b_ack", b_ack, 0);
      tick();
      n++;
    end
    chk("init2_len", n, 8);
    #1;
    chk("init_b_first_ack", b_ack, 1);
    tick();
    chk("init_b_valid", b_valid, 1);
    chk("init_b_data",  b_data,  4);
    b_req = 1'b0;

    // ---- contention: A addr 1, B addr 7 -> A,B,A,B... (last grant = B) ----
    a_req = 1'b1; a_addr = 3'd1;
    b_req = 1'b1; b_addr = 3'd7;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_a_ack", a_ack, (i % 2 == 0) ? 1 : 0);
      chk("rr_b_ack", b_ack, (i % 2 == 0) ? 0 : 1);
      tick();
      if (i % 2 == 0) begin
        chk("rr_a_valid", a_valid, 1);
        chk("rr_a_data",  a_data,  2);
        chk("rr_b_valid", b_valid, 0);
      end else begin
        chk("rr_b_valid", b_valid, 1);
        chk("rr_b_data",  b_data,  14);
        chk("rr_a_valid", a_valid, 0);
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    tick();
    chk("rr_idle_a", a_valid, 0);
    chk("rr_idle_b", b_valid, 0);

    // ---- B alone, addrs 0..3 back to back ---------------------------------
    b_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_addr = AW'(i);
      #1;
      chk("bb_b_ack", b_ack, 1);
      tick();
      chk("bb_b_valid", b_valid, 1);
      chk("bb_b_data",  b_data,  2 * i);
      chk("bb_a_valid", a_valid, 0);
    end
    b_req = 1'b0;

    // ---- cfg write addr 3 = 9 collides with A read of addr 3 --------------
    cfg_we = 1'b1; cfg_addr = 3'd3; cfg_data = 4'd9;
    a_req = 1'b1; a_addr = 3'd3;
    #1;
    chk("cfg_a_ack", a_ack, 0);
    chk("cfg_b_ack", b_ack, 0);
    tick();
    cfg_we = 1'b0;
    chk("cfg_no_valid", a_valid, 0);
    #1;
    chk("cfg_a_ack_next", a_ack, 1);
    tick();
    chk("cfg_a_valid", a_valid, 1);
    chk("cfg_a_data",  a_data,  9);

    // ---- reset with a read pending discards it and the cfg write ----------
    rst = 1'b1;
    #1;
    chk("rst_mid_a_ack", a_ack, 0);
    tick();
    a_req = 1'b0;
    chk("rst_mid_a_valid", a_valid, 0);
    chk("rst_mid_b_valid", b_valid, 0);
    chk("rst_mid_a_data",  a_data,  0);
    chk("rst_mid_busy",    busy,    1);
    rst = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    chk("init3_len", n, 8);
    a_req = 1'b1; a_addr = 3'd3;
    #1;
    chk("post_rst_a_ack", a_ack, 1);
    tick();
    a_req = 1'b0;
    chk("post_rst_a_valid", a_valid, 1);
    chk("post_rst_a_data",  a_data,  6);

    // ---- last-entry init value via a fresh reset --------------------------
    do_reset();
    a_req = 1'b1; a_addr = 3'd7;
    tick();
    a_req = 1'b0;
    chk("entry7_a_data", a_data, 14);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
